// File: rtl/sdram_pkg.sv
// sdram_pkg: shared FSM encoding, bank width and burst-address helper for the SDRAM frame arbiter
package sdram_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    localparam int BANK_W = 2;

    function automatic logic [31:0] burst_addr(input logic [31:0] idx, input logic [31:0] len);
        return idx * len;
    endfunction
endpackage

// File: rtl/sdram_frame_buf_ctrl.sv
// sdram_frame_buf_ctrl: ping-pong frame buffer ownership, swap on read frame start, drop on unconsumed overwrite
//   S_CLK, RST                       clock, async active-high reset
//   rd_frame_start / wr_frame_start  grant strobes for burst 0 of a read / write frame
//   wr_frame_end                     ack strobe for the last write burst of a frame
//   rd_sel                           buffer the current read grant must use (post-swap)
//   wr_buf, rd_buf, frame_valid, frame_drop  buffer state and status
module sdram_frame_buf_ctrl (
    input  logic S_CLK,
    input  logic RST,
    input  logic rd_frame_start,
    input  logic wr_frame_start,
    input  logic wr_frame_end,
    output logic rd_sel,
    output logic wr_buf,
    output logic rd_buf,
    output logic frame_valid,
    output logic frame_drop
);
    logic ready;
    logic swap;

    // ready is only set between a write-frame end and the next write-frame start,
    // so a swap can never tear a frame that is still being written
    assign swap   = rd_frame_start && ready;
    assign rd_sel = swap ? wr_buf : rd_buf;

    always_ff @(posedge S_CLK or posedge RST) begin
        if (RST) begin
            wr_buf      <= 1'b0;
            rd_buf      <= 1'b1;
            ready       <= 1'b0;
            frame_valid <= 1'b0;
            frame_drop  <= 1'b0;
        end else begin
            frame_drop <= wr_frame_start && ready;
            if (swap) begin
                rd_buf <= wr_buf;
                wr_buf <= rd_buf;
                ready  <= 1'b0;
            end else if (wr_frame_start && ready) begin
                ready <= 1'b0;
            end else if (wr_frame_end) begin
                ready       <= 1'b1;
                frame_valid <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/sdram_frame_arbiter.sv
// sdram_frame_arbiter: burst-level arbiter between camera write and VGA read paths of a single-port SDRAM
//   S_CLK, RST                 clock, async active-high reset
//   image_rd_en, vga_rd_req    level burst requests (write / read)
//   write_en/write_ack, read_en/read_ack   handshake with the SDRAM command engine
//   addr, bank                 burst start address and bank, stable while an en is high
//   frame_valid, wr_buf, rd_buf, wr_frame_done, frame_drop   frame buffer status
module sdram_frame_arbiter
    import sdram_pkg::*;
#(
    parameter int ADDR_W           = 20,
    parameter int BURST_LEN        = 8,
    parameter int BURSTS_PER_FRAME = 30,
    parameter int BANK_BASE        = 0
) (
    input  logic              S_CLK,
    input  logic              RST,
    input  logic              image_rd_en,
    input  logic              vga_rd_req,
    output logic              write_en,
    input  logic              write_ack,
    output logic              read_en,
    input  logic              read_ack,
    output logic [ADDR_W-1:0] addr,
    output logic [1:0]        bank,
    output logic              frame_valid,
    output logic              wr_buf,
    output logic              rd_buf,
    output logic              wr_frame_done,
    output logic              frame_drop
);
    localparam int                IDX_W = $clog2(BURSTS_PER_FRAME);
    localparam logic [IDX_W-1:0]  LAST  = IDX_W'(BURSTS_PER_FRAME - 1);
    localparam logic [BANK_W-1:0] BASE  = BANK_W'(BANK_BASE);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic             rd_grant, wr_grant, wr_done, rd_done;
    logic             rd_frame_start, wr_frame_start, wr_frame_end, rd_sel;

    always_ff @(posedge S_CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == IDLE)
            state_nxt = (vga_rd_req && frame_valid) ? READ : (image_rd_en ? WRITE : IDLE);
        else if ((state == WRITE && write_ack) || (state == READ && read_ack))
            state_nxt = IDLE;
    end

    always_comb begin
        rd_grant       = state == IDLE && state_nxt == READ;
        wr_grant       = state == IDLE && state_nxt == WRITE;
        wr_done        = state == WRITE && write_ack;
        rd_done        = state == READ && read_ack;
        rd_frame_start = rd_grant && rd_idx == '0;
        wr_frame_start = wr_grant && wr_idx == '0;
        wr_frame_end   = wr_done && wr_idx == LAST;
    end

    always_ff @(posedge S_CLK or posedge RST) begin
        if (RST) begin
            write_en      <= 1'b0;
            read_en       <= 1'b0;
            addr          <= '0;
            bank          <= BASE;
            wr_idx        <= '0;
            rd_idx        <= '0;
            wr_frame_done <= 1'b0;
        end else begin
            wr_frame_done <= wr_frame_end;
            if (rd_grant) begin
                read_en <= 1'b1;
                addr    <= ADDR_W'(burst_addr(32'(rd_idx), 32'(BURST_LEN)));
                bank    <= BASE + BANK_W'(rd_sel);
            end else if (wr_grant) begin
                write_en <= 1'b1;
                addr     <= ADDR_W'(burst_addr(32'(wr_idx), 32'(BURST_LEN)));
                bank     <= BASE + BANK_W'(wr_buf);
            end
            if (wr_done) begin
                write_en <= 1'b0;
                wr_idx   <= wr_idx == LAST ? '0 : wr_idx + 1'b1;
            end
            if (rd_done) begin
                read_en <= 1'b0;
                rd_idx  <= rd_idx == LAST ? '0 : rd_idx + 1'b1;
            end
        end
    end

    sdram_frame_buf_ctrl u_buf (
        .S_CLK          (S_CLK),
        .RST            (RST),
        .rd_frame_start (rd_frame_start),
        .wr_frame_start (wr_frame_start),
        .wr_frame_end   (wr_frame_end),
        .rd_sel         (rd_sel),
        .wr_buf         (wr_buf),
        .rd_buf         (rd_buf),
        .frame_valid    (frame_valid),
        .frame_drop     (frame_drop)
    );
endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// tb_sdram_frame_arbiter: scoreboard bench for the arbiter in default and small-frame configurations
module tb_sdram_frame_arbiter;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } burst_t;

    logic        S_CLK = 1'b0;
    logic        RST = 1'b1;
    logic        image_rd_en = 1'b0, vga_rd_req = 1'b0, write_ack = 1'b0, read_ack = 1'b0;
    logic        write_en, read_en, frame_valid, wr_buf, rd_buf, wr_frame_done, frame_drop;
    logic [19:0] addr;
    logic [1:0]  bank;
    logic        i2 = 1'b0, v2 = 1'b0, wa2 = 1'b0, ra2 = 1'b0;
    logic        we2, re2, fv2, wb2, rb2, wd2, fd2;
    logic [19:0] a2;
    logic [1:0]  b2;

    int     checks = 0, failures = 0, drop_cnt = 0;
    bit     auto = 1'b1;
    logic   pw = 1'b0, pr = 1'b0, pw2 = 1'b0, pr2 = 1'b0;
    burst_t wq[$], rq[$], w2q[$], r2q[$];
    burst_t e1, e2;

    always #5 S_CLK = ~S_CLK;

    sdram_frame_arbiter dut (
        .S_CLK(S_CLK), .RST(RST), .image_rd_en(image_rd_en), .vga_rd_req(vga_rd_req),
        .write_en(write_en), .write_ack(write_ack), .read_en(read_en), .read_ack(read_ack),
        .addr(addr), .bank(bank), .frame_valid(frame_valid), .wr_buf(wr_buf), .rd_buf(rd_buf),
        .wr_frame_done(wr_frame_done), .frame_drop(frame_drop)
    );

    sdram_frame_arbiter #(.ADDR_W(20), .BURST_LEN(16), .BURSTS_PER_FRAME(4), .BANK_BASE(2)) dut2 (
        .S_CLK(S_CLK), .RST(RST), .image_rd_en(i2), .vga_rd_req(v2),
        .write_en(we2), .write_ack(wa2), .read_en(re2), .read_ack(ra2),
        .addr(a2), .bank(b2), .frame_valid(fv2), .wr_buf(wb2), .rd_buf(rb2),
        .wr_frame_done(wd2), .frame_drop(fd2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge S_CLK);
        #1;
    endtask

    function automatic burst_t mk(input int a, input int b);
        burst_t t;
        t.a = a;
        t.b = b;
        return t;
    endfunction

    // engine model: ack three cycles after en is seen, unless the en was withdrawn meanwhile
    initial forever begin
        tick();
        if (auto && (write_en || read_en)) begin
            repeat (2) @(posedge S_CLK);
            #1;
            if (auto && write_en) write_ack = 1'b1;
            else if (auto && read_en) read_ack = 1'b1;
            tick();
            write_ack = 1'b0;
            read_ack = 1'b0;
        end
    end

    initial forever begin
        tick();
        if (we2 || re2) begin
            repeat (2) @(posedge S_CLK);
            #1;
            if (we2) wa2 = 1'b1;
            else if (re2) ra2 = 1'b1;
            tick();
            wa2 = 1'b0;
            ra2 = 1'b0;
        end
    end

    always @(negedge S_CLK) begin
        if (write_en && !pw) begin
            chk("wr_pending", 32'(wq.size() > 0), 1);
            if (wq.size() > 0) begin
                e1 = wq.pop_front();
                chk("wr_addr", 32'(addr), e1.a);
                chk("wr_bank", 32'(bank), e1.b);
            end
        end
        if (read_en && !pr) begin
            chk("rd_pending", 32'(rq.size() > 0), 1);
            if (rq.size() > 0) begin
                e1 = rq.pop_front();
                chk("rd_addr", 32'(addr), e1.a);
                chk("rd_bank", 32'(bank), e1.b);
            end
        end
        if (frame_drop) begin
            drop_cnt++;
            chk("drop_addr", 32'(addr), 0);
            chk("drop_with_grant", 32'(write_en && !pw), 1);
        end
        pw = write_en;
        pr = read_en;
    end

    always @(negedge S_CLK) begin
        if (we2 && !pw2) begin
            chk("wr2_pending", 32'(w2q.size() > 0), 1);
            if (w2q.size() > 0) begin
                e2 = w2q.pop_front();
                chk("wr2_addr", 32'(a2), e2.a);
                chk("wr2_bank", 32'(b2), e2.b);
            end
        end
        if (re2 && !pr2) begin
            chk("rd2_pending", 32'(r2q.size() > 0), 1);
            if (r2q.size() > 0) begin
                e2 = r2q.pop_front();
                chk("rd2_addr", 32'(a2), e2.a);
                chk("rd2_bank", 32'(b2), e2.b);
            end
        end
        chk("drop2_none", 32'(fd2), 0);
        pw2 = we2;
        pr2 = re2;
    end

    initial begin
        int n, d;
        repeat (3) tick();
        chk("rst_write_en", 32'(write_en), 0);
        chk("rst_read_en", 32'(read_en), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_bank", 32'(bank), 0);
        chk("rst_frame_valid", 32'(frame_valid), 0);
        chk("rst_wr_buf", 32'(wr_buf), 0);
        chk("rst_rd_buf", 32'(rd_buf), 1);
        chk("rst_wr_frame_done", 32'(wr_frame_done), 0);
        chk("rst_frame_drop", 32'(frame_drop), 0);
        chk("rst_bank2", 32'(b2), 2);
        @(negedge S_CLK) RST = 1'b0;

        // frame 0: 30 write bursts on bank 0
        for (int i = 0; i < 30; i++) wq.push_back(mk(i * 8, 0));
        image_rd_en = 1'b1;
        d = 0;
        for (n = 0; n < 400 && !wr_frame_done; n++) begin
            tick();
            if (wr_frame_done) d++;
        end
        image_rd_en = 1'b0;
        chk("f0_done_pulse", 32'(d), 1);
        chk("f0_queue_empty", 32'(wq.size()), 0);
        chk("f0_frame_valid", 32'(frame_valid), 1);
        tick();
        chk("f0_done_one_cycle", 32'(wr_frame_done), 0);

        // contention: read wins, swaps, writer moves to the fresh buffer
        rq.push_back(mk(0, 0));
        wq.push_back(mk(0, 1));
        vga_rd_req = 1'b1;
        image_rd_en = 1'b1;
        for (n = 0; n < 20 && !read_en; n++) tick();
        chk("rd_granted", 32'(read_en), 1);
        chk("rd_no_write", 32'(write_en), 0);
        vga_rd_req = 1'b0;
        chk("swap_rd_buf", 32'(rd_buf), 0);
        chk("swap_wr_buf", 32'(wr_buf), 1);
        for (n = 0; n < 20 && !write_en; n++) tick();
        image_rd_en = 1'b0;
        chk("wr_after_rd", 32'(write_en), 1);
        for (n = 0; n < 20 && write_en; n++) tick();
        chk("wr1_idle", 32'(write_en), 0);

        // stray acks are ignored
        auto = 1'b0;
        tick();
        write_ack = 1'b1;
        tick();
        write_ack = 1'b0;
        wq.push_back(mk(8, 1));
        image_rd_en = 1'b1;
        for (n = 0; n < 20 && !write_en; n++) tick();
        image_rd_en = 1'b0;
        chk("stray_wr_en", 32'(write_en), 1);
        read_ack = 1'b1;
        tick();
        read_ack = 1'b0;
        tick();
        chk("stray_rd_ack_hold", 32'(write_en), 1);
        write_ack = 1'b1;
        tick();
        write_ack = 1'b0;
        chk("wr_ack_release", 32'(write_en), 0);
        auto = 1'b1;
        wq.push_back(mk(16, 1));
        image_rd_en = 1'b1;

        // async reset while bursting at wr_idx 17
        for (int i = 3; i <= 17; i++) wq.push_back(mk(i * 8, 1));
        for (n = 0; n < 400 && wq.size() != 0; n++) tick();
        chk("reach_idx17", 32'(wq.size()), 0);
        chk("idx17_active", 32'(write_en), 1);
        #2;
        RST = 1'b1;
        image_rd_en = 1'b0;
        #1;
        chk("rst_mid_write_en", 32'(write_en), 0);
        chk("rst_mid_addr", 32'(addr), 0);
        chk("rst_mid_wr_buf", 32'(wr_buf), 0);
        chk("rst_mid_frame_valid", 32'(frame_valid), 0);
        @(negedge S_CLK) RST = 1'b0;

        // two full frames with no reader: second frame start drops the first
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 30; i++) wq.push_back(mk(i * 8, 0));
        drop_cnt = 0;
        image_rd_en = 1'b1;
        d = 0;
        for (n = 0; n < 1000 && d < 2; n++) begin
            tick();
            if (wr_frame_done) d++;
        end
        image_rd_en = 1'b0;
        chk("two_frames_done", 32'(d), 2);
        chk("two_frames_queue", 32'(wq.size()), 0);
        chk("drop_count", 32'(drop_cnt), 1);
        chk("drop_wr_buf", 32'(wr_buf), 0);
        chk("drop_rd_buf", 32'(rd_buf), 1);
        chk("drop_frame_valid", 32'(frame_valid), 1);

        // small configuration: 4 bursts of 16 on bank 2, then bank 3 after the swap
        for (int i = 0; i < 4; i++) w2q.push_back(mk(i * 16, 2));
        i2 = 1'b1;
        for (n = 0; n < 100 && !wd2; n++) tick();
        i2 = 1'b0;
        chk("f2_done", 32'(wd2), 1);
        chk("f2_valid", 32'(fv2), 1);
        r2q.push_back(mk(0, 2));
        w2q.push_back(mk(0, 3));
        v2 = 1'b1;
        i2 = 1'b1;
        for (n = 0; n < 20 && !re2; n++) tick();
        v2 = 1'b0;
        chk("f2_rd_granted", 32'(re2), 1);
        for (n = 0; n < 20 && !we2; n++) tick();
        i2 = 1'b0;
        for (n = 0; n < 20 && we2; n++) tick();
        chk("f2_rd_buf", 32'(rb2), 0);
        chk("f2_wr_buf", 32'(wb2), 1);
        chk("f2_queues", 32'(w2q.size() + r2q.size()), 0);
        chk("final_queues", 32'(wq.size() + rq.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
